// File: rtl/chip_driver_pkg.sv
// Shared types and defaults for the ISML chip serial driver.
package chip_driver_pkg;

  typedef enum logic [1:0] {
    RST_LOW,
    RST_SHIFT,
    RUN
  } state_t;

  // ld_ch is 4 bits wide, which caps a frame at 16 channels.
  localparam int CH_IDX_W = 4;

  localparam logic [7:0] DEF_PAT_A     = 8'hFF;
  localparam logic [7:0] DEF_PAT_B     = 8'hFE;
  localparam logic [7:0] DEF_RESET_VAL = 8'hFF;

  function automatic int word_len(input int data_w, input bit parity);
    return parity ? data_w + 1 : data_w;
  endfunction

endpackage

// File: rtl/chip_word_shifter.sv
// Word serialiser: loads a word, emits it MSB first on bit_q, optionally
// followed by one even-parity bit; word_done marks the last bit of the word.
module chip_word_shifter #(
  parameter int DATA_W   = 8,
  parameter int WORD_LEN = DATA_W
) (
  input  logic              clk_in,
  input  logic              bt_res,
  input  logic              load,
  input  logic              with_par,
  input  logic [DATA_W-1:0] data,
  output logic              bit_q,
  output logic              word_done
);

  localparam int CNT_W = $clog2(WORD_LEN + 1);

  logic [DATA_W-1:0] shreg;
  logic              par_q;
  logic              par_en_q;
  logic              busy;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  last;

  assign last      = par_en_q ? CNT_W'(WORD_LEN - 1) : CNT_W'(DATA_W - 1);
  assign word_done = busy && (cnt == last);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge bt_res) begin
    if (bt_res) begin
      shreg    <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_q    <= 1'b0;
    end else if (load) begin
      bit_q    <= data[DATA_W-1];
      shreg    <= data << 1;
      par_q    <= ^data;
      par_en_q <= with_par;
      cnt      <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      cnt   <= cnt + 1'b1;
      shreg <= shreg << 1;
      // After the last data bit only a parity bit can follow.
      bit_q <= (cnt == CNT_W'(DATA_W - 1)) ? (par_q & par_en_q) : shreg[DATA_W-1];
    end
  end

endmodule

// File: rtl/chip_serial_driver.sv
// Multi-channel serial driver for the ISML test chip: reset sequence, then
// one word per channel per frame. Optional parity bit: define FRAME_PARITY_EN.
module chip_serial_driver
  import chip_driver_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                DATA_W      = 8,
  parameter int                SEL_W       = 4,
  parameter int                CYCLE_LEN   = 250,
  parameter int                RESET_WORDS = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = DATA_W'(DEF_RESET_VAL),
  parameter logic [DATA_W-1:0] PAT_A       = DATA_W'(DEF_PAT_A),
  parameter logic [DATA_W-1:0] PAT_B       = DATA_W'(DEF_PAT_B)
) (
  input  logic                    clk_in,
  input  logic                    bt_res,
  input  logic [NUM_CH*SEL_W-1:0] ch_sel,
  input  logic                    mode,
  input  logic                    ld_valid,
  input  logic [CH_IDX_W-1:0]     ld_ch,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  output logic                    ld_err,
  output logic                    resn,
  output logic                    enable,
  output logic                    clk_out,
  output logic                    serial_din,
  output logic [SEL_W-1:0]        sel,
  output logic                    frame_start,
  output logic                    swap
);

`ifdef FRAME_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int WORD_LEN = word_len(DATA_W, PARITY_EN);
  localparam int FC_W     = $clog2(CYCLE_LEN + 1);
  localparam int RW_W     = $clog2(RESET_WORDS + 1);

  state_t                state, state_nx;
  logic                  gate_q;
  logic                  mode_q;
  logic [CH_IDX_W-1:0]   word_cnt;
  logic [FC_W-1:0]       frame_cnt;
  logic [RW_W-1:0]       rw_cnt;
  logic [DATA_W-1:0]     active    [NUM_CH];
  logic [DATA_W-1:0]     shadow    [NUM_CH];
  logic [DATA_W-1:0]     shadow_nx [NUM_CH];

  logic                  load, new_frame, run_word, word_done;
  logic                  ld_acc, ld_ok, toggle, swap_nx, mode_nx;
  logic [CH_IDX_W-1:0]   idx;
  logic [DATA_W-1:0]     word_data;
  logic [SEL_W-1:0]      sel_nx;

  assign clk_out  = ~clk_in & gate_q;
  assign ld_acc   = ld_valid & ld_ready;
  assign ld_ok    = ld_acc && (int'(ld_ch) < NUM_CH);
  assign run_word = new_frame || (state == RUN);
  assign idx      = new_frame ? '0 : word_cnt + 1'b1;
  // Every CYCLE_LEN completed frames the pattern half flips.
  assign toggle   = new_frame && (state == RUN) && (frame_cnt == FC_W'(CYCLE_LEN - 1));
  assign swap_nx  = swap ^ toggle;
  assign mode_nx  = new_frame ? mode : mode_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    new_frame = 1'b0;
    case (state)
      RST_LOW: begin
        state_nx = RST_SHIFT;
        load     = 1'b1;
      end
      RST_SHIFT: begin
        if (word_done) begin
          load = 1'b1;
          if (rw_cnt == RW_W'(RESET_WORDS - 1)) begin
            state_nx  = RUN;
            new_frame = 1'b1;
          end
        end
      end
      RUN: begin
        if (word_done) begin
          load      = 1'b1;
          new_frame = (word_cnt == CH_IDX_W'(NUM_CH - 1));
        end
      end
      default: state_nx = RST_LOW;
    endcase
  end

  // The first word of a frame sees the committed shadow, including a write
  // accepted on the commit cycle itself.
  always_comb begin
    shadow_nx = shadow;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ld_ok && (ld_ch == CH_IDX_W'(k))) shadow_nx[k] = ld_data;
    end
    word_data = RESET_VAL;
    sel_nx    = '0;
    if (run_word) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (idx == CH_IDX_W'(k)) begin
          sel_nx = ch_sel[k*SEL_W +: SEL_W];
          if (mode_nx) word_data = new_frame ? shadow_nx[k] : active[k];
          else         word_data = (((k % 2) == 0) ^ swap_nx) ? PAT_A : PAT_B;
        end
      end
    end
  end

  chip_word_shifter #(
    .DATA_W   (DATA_W),
    .WORD_LEN (WORD_LEN)
  ) u_shifter (
    .clk_in    (clk_in),
    .bt_res    (bt_res),
    .load      (load),
    .with_par  (run_word & PARITY_EN),
    .data      (word_data),
    .bit_q     (serial_din),
    .word_done (word_done)
  );

  // NOTE: the shadow/active word arrays are reset because a reset must
  // discard host data and restart from RESET_VAL.
  always_ff @(posedge clk_in or posedge bt_res) begin
    if (bt_res) begin
      state       <= RST_LOW;
      resn        <= 1'b0;
      enable      <= 1'b0;
      gate_q      <= 1'b0;
      sel         <= '0;
      ld_ready    <= 1'b0;
      ld_err      <= 1'b0;
      frame_start <= 1'b0;
      swap        <= 1'b0;
      mode_q      <= 1'b0;
      word_cnt    <= '0;
      frame_cnt   <= '0;
      rw_cnt      <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        active[k] <= RESET_VAL;
        shadow[k] <= RESET_VAL;
      end
    end else begin
      state       <= state_nx;
      resn        <= (state_nx != RST_LOW);
      gate_q      <= (state_nx != RST_LOW);
      ld_ready    <= (state_nx != RST_LOW);
      enable      <= (state_nx == RUN);
      frame_start <= new_frame;
      ld_err      <= ld_acc && !ld_ok;
      shadow      <= shadow_nx;
      if (load) begin
        sel <= sel_nx;
        if (run_word) word_cnt <= idx;
      end
      if (load && (state == RST_SHIFT) && !new_frame) rw_cnt <= rw_cnt + 1'b1;
      if (new_frame) begin
        mode_q <= mode;
        active <= shadow_nx;
        swap   <= swap_nx;
        if (state == RUN) frame_cnt <= toggle ? '0 : frame_cnt + 1'b1;
      end
    end
  end

endmodule
